cpu_wait_sequencer: RTL and testbench

Wait-state sequencer for the 6309E bus-cycle clock generator. It merges two requesters: the V9958 nWAIT line and a fixed wait-state request from address decode for slow devices. From these it drives a single STALL request that freezes the E/Q quadrature generator in its E-high/Q-low quarter. It runs in the 48 MHz master domain, alongside the clock generator, and adds a watchdog so a stuck nWAIT cannot hang the CPU.

---
 rtl/cpu_wait_sequencer_if.sv | 23 ++
 rtl/cpu_wait_sequencer.sv | 129 ++++++++++++
 tb/tb_cpu_wait_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_wait_sequencer_if.sv
// Bus-cycle handshake between the 6309E clock generator / address decode and the
// wait-state sequencer. The sequencer connects through the slave modport.
interface cpu_wait_sequencer_if;
  logic       TICK12;
  logic [1:0] PHASE;
  logic       nWAIT;
  logic       SLOWSEL;
  logic       CLR_ERR;
  logic       STALL;
  logic       BUSY;
  logic       TMO_ERR;
  logic [9:0] LAST_LEN;

  modport master (
    output TICK12, PHASE, nWAIT, SLOWSEL, CLR_ERR,
    input  STALL, BUSY, TMO_ERR, LAST_LEN
  );

  modport slave (
    input  TICK12, PHASE, nWAIT, SLOWSEL, CLR_ERR,
    output STALL, BUSY, TMO_ERR, LAST_LEN
  );
endinterface

// File: rtl/cpu_wait_sequencer.sv
// Wait-state sequencer: merges V9958 nWAIT and slow-device decode into one STALL
// for the E/Q generator. Define CPU_WAIT_TIMEOUT_EN to add the stuck-nWAIT watchdog.
module cpu_wait_sequencer #(
  parameter int WS_SLOW = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                  MHZ48,
  input  logic                  nRESET,
  cpu_wait_sequencer_if.slave   bus
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_STRETCH = 1'b1
  } state_t;

  localparam logic [3:0] WS_LOAD = 4'(WS_SLOW);
  localparam logic [9:0] LEN_MAX = 10'd1023;

  state_t     state_q, state_d;
  logic [1:0] nwait_sync_q, nwait_sync_d;
  logic [3:0] ws_cnt_q, ws_cnt_d;
  logic [9:0] len_cnt_q, len_cnt_d;
  logic [9:0] last_len_q, last_len_d;
  logic       stall_q, stall_d;
  logic       tmo_err_q, tmo_err_d;

  logic       nwait_s;
  logic       decision;
  logic [9:0] len_inc;
  logic [3:0] ws_dec;
  logic       rel;

  assign nwait_s  = nwait_sync_q[1];
  assign decision = bus.TICK12 && (bus.PHASE == 2'b11);

`ifdef CPU_WAIT_TIMEOUT_EN
  localparam logic [9:0] TMO_LIM = 10'(TIMEOUT);
`else
  localparam int unused_timeout = TIMEOUT;
  logic unused_clr_err;
  assign unused_clr_err = bus.CLR_ERR;
`endif

  always_comb begin
    state_d      = state_q;
    nwait_sync_d = {nwait_sync_q[0], bus.nWAIT};
    ws_cnt_d     = ws_cnt_q;
    len_cnt_d    = len_cnt_q;
    last_len_d   = last_len_q;
    stall_d      = stall_q;
    tmo_err_d    = tmo_err_q;
    len_inc      = (len_cnt_q == LEN_MAX) ? LEN_MAX : len_cnt_q + 10'd1;
    ws_dec       = (ws_cnt_q != 4'd0) ? ws_cnt_q - 4'd1 : ws_cnt_q;
    rel          = 1'b0;

`ifdef CPU_WAIT_TIMEOUT_EN
    if (bus.CLR_ERR) begin
      tmo_err_d = 1'b0;
    end
`else
    tmo_err_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        stall_d = 1'b0;
        // Only the 11->10 tick may start a stretch, so each bus cycle stalls at most once.
        if (decision && ((bus.SLOWSEL && (WS_SLOW > 0)) || !nwait_s)) begin
          state_d   = S_STRETCH;
          ws_cnt_d  = bus.SLOWSEL ? WS_LOAD : 4'd0;
          len_cnt_d = 10'd0;
          stall_d   = 1'b1;
        end
      end

      S_STRETCH: begin
        if (bus.TICK12) begin
          len_cnt_d = len_inc;
          ws_cnt_d  = ws_dec;
          rel       = (ws_dec == 4'd0) && nwait_s;
`ifdef CPU_WAIT_TIMEOUT_EN
          if (len_inc >= TMO_LIM) begin
            rel       = 1'b1;
            tmo_err_d = 1'b1;
          end
`endif
          if (rel) begin
            state_d = S_IDLE;
            stall_d = 1'b0;
            // LAST_LEN is the full E-high/Q-low quarter, i.e. held ticks plus the entry tick.
            last_len_d = (len_inc == LEN_MAX) ? LEN_MAX : len_inc + 10'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        stall_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MHZ48 or negedge nRESET) begin
    if (!nRESET) begin
      state_q      <= S_IDLE;
      nwait_sync_q <= 2'b11;
      ws_cnt_q     <= 4'd0;
      len_cnt_q    <= 10'd0;
      last_len_q   <= 10'd0;
      stall_q      <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      nwait_sync_q <= nwait_sync_d;
      ws_cnt_q     <= ws_cnt_d;
      len_cnt_q    <= len_cnt_d;
      last_len_q   <= last_len_d;
      stall_q      <= stall_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  assign bus.STALL    = stall_q;
  assign bus.BUSY     = (state_q == S_STRETCH);
  assign bus.TMO_ERR  = tmo_err_q;
  assign bus.LAST_LEN = last_len_q;

endmodule

// File: tb/tb_cpu_wait_sequencer.sv
// Scoreboard bench for cpu_wait_sequencer: a tick-level reference model predicts each
// bus cycle's quarter length, LAST_LEN and TMO_ERR; a monitor checks them at cycle end.
`timescale 1ns/1ps
module tb_cpu_wait_sequencer;
  localparam int WS  = 3;
  localparam int TMO = 16;

  logic MHZ48  = 1'b0;
  logic nRESET = 1'b0;

  cpu_wait_sequencer_if bus();

  cpu_wait_sequencer #(.WS_SLOW(WS), .TIMEOUT(TMO)) dut (
    .MHZ48  (MHZ48),
    .nRESET (nRESET),
    .bus    (bus)
  );

  always #10 MHZ48 = ~MHZ48;

  typedef struct {
    int         id;
    bit         stalled;
    int         quarter;
    logic [9:0] last_len;
    bit         tmo;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_en = 0;
  int         txn_id = 0;
  logic [9:0] m_last = 10'd0;
  bit         m_tmo = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // E/Q generator model: a tick every 4 cycles, PHASE held at 10 while STALL was high.
  int tick_cnt = 0;
  bit stall_seen = 0;
  initial begin
    bus.TICK12 = 1'b0;
    bus.PHASE  = 2'b00;
    forever begin
      @(negedge MHZ48);
      if (bus.TICK12 && !(stall_seen && bus.PHASE == 2'b10)) begin
        case (bus.PHASE)
          2'b00:   bus.PHASE = 2'b01;
          2'b01:   bus.PHASE = 2'b11;
          2'b11:   bus.PHASE = 2'b10;
          default: bus.PHASE = 2'b00;
        endcase
      end
      tick_cnt   = (tick_cnt + 1) % 4;
      bus.TICK12 = (tick_cnt == 3);
      stall_seen = bus.STALL;
    end
  end

  // Reference model at bus-cycle level: release tick index after the decision tick.
  task automatic predict(input bit slow, input bit nwl, input int k, output exp_t e);
    int r;
    bit t;
    r = 0;
    t = 0;
    if (slow && WS > 0) r = WS;
    if (nwl && (k + 1) > r) r = k + 1;
`ifdef CPU_WAIT_TIMEOUT_EN
    if (r >= TMO) begin
      r = TMO;
      t = 1;
    end
`endif
    e.id      = txn_id;
    e.stalled = (r > 0);
    e.quarter = r + 1;
    if (r > 0) m_last = (r + 1 > 1023) ? 10'd1023 : 10'(r + 1);
    if (t) m_tmo = 1;
    e.last_len = m_last;
    e.tmo      = m_tmo;
  endtask

  // Monitor: checks STALL at the decision tick and everything else when PHASE leaves 10.
  int qlen = 0;
  bit busy_bad = 0;
  initial begin
    exp_t e;
    forever begin
      @(posedge MHZ48);
      #1;
      if (bus.BUSY !== bus.STALL) busy_bad = 1;
      if (bus.TICK12) begin
        if (bus.PHASE == 2'b11) begin
          if (mon_en && exp_q.size() > 0)
            check($sformatf("stall_rise[%0d]", exp_q[0].id), {31'b0, bus.STALL}, {31'b0, exp_q[0].stalled});
        end else if (bus.PHASE == 2'b10) begin
          qlen++;
        end else if (bus.PHASE == 2'b00) begin
          if (qlen > 0 && mon_en) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_cycle: got quarter %0d expected no bus cycle", qlen);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("quarter[%0d]", e.id), qlen, e.quarter);
              check($sformatf("last_len[%0d]", e.id), {22'b0, bus.LAST_LEN}, {22'b0, e.last_len});
              check($sformatf("tmo_err[%0d]", e.id), {31'b0, bus.TMO_ERR}, {31'b0, e.tmo});
              check($sformatf("busy_vs_stall[%0d]", e.id), {31'b0, busy_bad}, 32'd0);
            end
          end
          qlen = 0;
          busy_bad = 0;
        end
      end
    end
  end

  task automatic wait_tick(input bit any_ph, input logic [1:0] ph, output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge MHZ48);
      if (bus.TICK12 && (any_ph || bus.PHASE == ph)) begin
        ok = 1;
        break;
      end
    end
    #2;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_tick: got no tick with phase %b expected one within budget", ph);
    end
  endtask

  task automatic run_txn(input bit slow, input bit nwl, input int k, input bit late,
                         input bit tmo_case, input bit clr, output bit ok);
    exp_t e;
    wait_tick(0, 2'b01, ok);
    if (!ok) return;
    if (clr) begin
      bus.CLR_ERR = 1'b1;
      @(posedge MHZ48);
      #2;
      bus.CLR_ERR = 1'b0;
      m_tmo = 0;
    end
    bus.SLOWSEL = slow;
    bus.nWAIT   = !nwl;
    txn_id++;
    predict(slow, nwl, tmo_case ? 100000 : k, e);
    exp_q.push_back(e);
    mon_en = 1;
    wait_tick(1, 2'b00, ok);
    if (!ok) return;
    if (late) bus.nWAIT = 1'b0;
    bus.SLOWSEL = 1'($urandom_range(0, 1));
    if (tmo_case) begin
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
        @(posedge MHZ48);
        #1;
        if (!bus.STALL) begin
          ok = 1;
          break;
        end
      end
      #1;
      bus.nWAIT = 1'b1;
      if (!ok) begin
        n_cmp++;
        n_bad++;
        $display("FAIL timeout_release: got STALL stuck high expected forced release");
      end
    end else if (nwl) begin
      for (int j = 0; j < k && ok; j++) wait_tick(1, 2'b00, ok);
      bus.nWAIT = 1'b1;
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #5_000_000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got simulation still running expected finish");
    summary();
    $finish;
  end

  initial begin
    bit ok;
    bit slow, nwl, clr;
    int k;
    bus.nWAIT   = 1'b1;
    bus.SLOWSEL = 1'b0;
    bus.CLR_ERR = 1'b0;
    nRESET      = 1'b0;
    repeat (5) @(posedge MHZ48);
    #1;
    check("reset_stall", {31'b0, bus.STALL}, 32'd0);
    check("reset_busy", {31'b0, bus.BUSY}, 32'd0);
    check("reset_tmo", {31'b0, bus.TMO_ERR}, 32'd0);
    check("reset_last_len", {22'b0, bus.LAST_LEN}, 32'd0);
    nRESET = 1'b1;
    ok = 1;

    // Directed: slow only, nWAIT 10 periods, both sources each way, late nWAIT.
    if (ok) run_txn(1, 0, 0, 0, 0, 0, ok);
    if (ok) run_txn(0, 1, 9, 0, 0, 0, ok);
    if (ok) run_txn(1, 1, 7, 0, 0, 0, ok);
    if (ok) run_txn(1, 1, 0, 0, 0, 0, ok);
    if (ok) run_txn(0, 0, 0, 1, 0, 0, ok);
    if (ok) run_txn(0, 1, 2, 0, 0, 0, ok);
`ifdef CPU_WAIT_TIMEOUT_EN
    if (ok) run_txn(0, 1, 0, 0, 1, 0, ok);
`endif
    if (ok) run_txn(1, 0, 0, 0, 0, 1, ok);

    for (int n = 0; n < 36 && ok; n++) begin
      slow = 1'($urandom_range(0, 1));
      nwl  = 1'($urandom_range(0, 1));
      k    = $urandom_range(0, 12);
      clr  = ($urandom_range(0, 7) == 0);
      run_txn(slow, nwl, k, 0, 0, clr, ok);
    end

    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge MHZ48);
    #3;
    check("queue_drained", exp_q.size(), 32'd0);
    mon_en = 0;

    // Reset asserted in the middle of a slow stretch.
    wait_tick(0, 2'b01, ok);
    bus.SLOWSEL = 1'b1;
    bus.nWAIT   = 1'b0;
    wait_tick(1, 2'b00, ok);
    wait_tick(1, 2'b00, ok);
    #1;
    check("pre_reset_stall", {31'b0, bus.STALL}, 32'd1);
    nRESET = 1'b0;
    #1;
    check("midreset_stall", {31'b0, bus.STALL}, 32'd0);
    check("midreset_busy", {31'b0, bus.BUSY}, 32'd0);
    check("midreset_last_len", {22'b0, bus.LAST_LEN}, 32'd0);
    check("midreset_tmo", {31'b0, bus.TMO_ERR}, 32'd0);
    bus.nWAIT   = 1'b1;
    bus.SLOWSEL = 1'b0;
    repeat (3) @(posedge MHZ48);
    nRESET = 1'b1;
    repeat (2) @(posedge MHZ48);
    summary();
    $finish;
  end
endmodule
